instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Consumer end of the 9-bit instruction ROM interface: owns the program counter, drives the ROM address, latches the returned word into an instruction register (IR) and hands it to the decoder.
- Applies jump and relative-branch redirects, flushes the in-flight fetch on a redirect, and detects halt.
- Sits between the instruction ROM and the decode/execute stage of the core.

Parameters:
- ADDR_W, 8, ROM address / PC width.
- INSTR_W, 9, instruction width.
- HALT_WORD, 9'b0111_00_010, encoding that stops fetch.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or restarts execution at address 0.
- stall  in  1  execute stage busy; freezes PC, IR and state.
- rom_address  out  ADDR_W  address to the ROM, equal to pc.
- rom_instruction  in  INSTR_W  ROM data; combinational from rom_address, same cycle.
- jump_en  in  1  execute requests an absolute jump.
- jump_target  in  ADDR_W  absolute target.
- branch_en  in  1  execute requests a relative branch.
- branch_offset  in  ADDR_W  two's-complement offset, relative to the branching instruction's address.
- ir  out  INSTR_W  current instruction.
- ir_pc  out  ADDR_W  address ir was fetched from.
- ir_valid  out  1  ir holds a real instruction.
- pc  out  ADDR_W  next fetch address.
- halted  out  1  HALTED state.
- instr_count  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset (async, any time, including mid-run):
  - pc=0, ir=0, ir_pc=0, ir_valid=0, halted=0, instr_count=0.
  - State goes to IDLE.
- States: IDLE, RUN, HALTED.
- IDLE:
  - Outputs held.
  - start=1: go to RUN, pc=0, ir_valid=0.
- RUN, stall=1: nothing changes. Redirect inputs are ignored.
- RUN, stall=0, priority order:
  1. ir_valid and ir==HALT_WORD:
     - Go to HALTED; ir_valid<=0; pc frozen.
     - jump_en and branch_en are ignored.
     - The halt itself counts as retired.
  2. ir_valid and jump_en:
     - pc<=jump_target; ir_valid<=0, i.e. one bubble; the in-flight fetch is discarded.
     - Jump wins over a simultaneous branch_en.
  3. ir_valid and branch_en:
     - pc<=ir_pc+branch_offset, modulo 2^ADDR_W; ir_valid<=0.
  4. Otherwise:
     - ir<=rom_instruction; ir_pc<=pc; ir_valid<=1; pc<=pc+1.
     - pc wraps 255->0 silently.
  - Redirect inputs are meaningful only while ir_valid=1. With ir_valid=0 they are ignored.
- instr_count increments on every RUN cycle with stall=0 and ir_valid=1, and saturates at all-ones.
- HALTED:
  - halted=1; ir_valid=0; pc frozen.
  - start=1: go to RUN, pc=0, halted=0. instr_count is not cleared, only reset clears it.
- start while in RUN is ignored.
- Latency:
  - First valid ir appears 2 edges after start: the start edge, then the fetch edge.
  - Each redirect costs exactly 1 bubble cycle.

Decomposition:
- Shared ISA package:
  - HALT_WORD, the opcode field position [8:5], ADDR_W and INSTR_W.
  - State enum {IDLE, RUN, HALTED}.
- No sub-module needed. The next-PC mux may be a local function; it stays in this module.

Test Plan:
- Reset then start, ROM words 0..3 distinct, no stall:
  - ir_valid rises 2 edges after start.
  - ir_pc steps 0,1,2,3 on consecutive cycles.
  - rom_address leads ir_pc by one.
- branch_en=1 with offset 8'h02 while ir_pc=10:
  - Next cycle ir_valid=0 and pc=12.
  - Following cycle ir_pc=12.
  - Word 11 never becomes valid.
- jump_en=1 (target 8) and branch_en=1 (offset 2) together at ir_pc=15:
  - pc=8, one bubble, then ir_pc=8 (jump wins).
- HALT_WORD at address 19 with jump_en held high:
  - halted=1 next cycle, pc frozen at 20, ir_valid=0.
  - instr_count equals the number retired including the halt.
  - start then restarts at ir_pc=0.
- stall held 3 cycles mid-run, with branch_en pulsed during the stall:
  - pc, ir, ir_pc and instr_count unchanged; the branch has no effect.
  - Fetch resumes in sequence afterwards.
- Jump to 255 and run sequentially:
  - ir_pc goes 255 then 0.
- Assert reset asynchronously between edges while in RUN:
  - All outputs go to zero immediately, state is IDLE, and ir_valid stays 0 until start.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared ISA definitions for the fetch stage: word geometry, halt encoding
// and the fetch control states.
package instruction_fetch_pkg;

  localparam int ISA_ADDR_W = 8;
  localparam int ISA_INSTR_W = 9;
  localparam int ISA_CNT_W = 16;
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 5;
  localparam logic [ISA_INSTR_W-1:0] ISA_HALT_WORD = 9'b0111_00_010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] get_opcode(input logic [ISA_INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the ROM address, latches the returned word
// into the IR and applies jump/branch redirects and halt detection.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = ISA_ADDR_W,
  parameter int INSTR_W = ISA_INSTR_W,
  parameter logic [INSTR_W-1:0] HALT_WORD = ISA_HALT_WORD,
  parameter int CNT_W = ISA_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_offset,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count
);

  fetch_state_t       r_state, w_state_next;
  logic [ADDR_W-1:0]  r_pc, w_pc_next;
  logic [INSTR_W-1:0] r_ir, w_ir_next;
  logic [ADDR_W-1:0]  r_ir_pc, w_ir_pc_next;
  logic               r_ir_valid, w_ir_valid_next;
  logic               r_halted, w_halted_next;
  logic [CNT_W-1:0]   r_count, w_count_next;

  logic w_active;
  logic w_is_halt;

  // Redirect target; the branch is relative to the branching instruction, not pc.
  function automatic logic [ADDR_W-1:0] redirect_pc(
    input logic              jmp,
    input logic [ADDR_W-1:0] tgt,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] ofs
  );
    return jmp ? tgt : ADDR_W'(base + ofs);
  endfunction

  assign w_active  = (r_state == ST_RUN) && !stall;
  assign w_is_halt = r_ir_valid && (r_ir == HALT_WORD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_ir       <= w_ir_next;
      r_ir_pc    <= w_ir_pc_next;
      r_ir_valid <= w_ir_valid_next;
      r_halted   <= w_halted_next;
      r_count    <= w_count_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_ir_next       = r_ir;
    w_ir_pc_next    = r_ir_pc;
    w_ir_valid_next = r_ir_valid;
    w_halted_next   = r_halted;
    w_count_next    = r_count;

    // Every unstalled RUN cycle holding a valid IR retires it, halt included.
    if (w_active && r_ir_valid && (r_count != {CNT_W{1'b1}})) begin
      w_count_next = r_count + 1'b1;
    end

    unique case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          w_state_next    = ST_RUN;
          w_pc_next       = '0;
          w_ir_valid_next = 1'b0;
          w_halted_next   = 1'b0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (w_is_halt) begin
            w_state_next    = ST_HALTED;
            w_ir_valid_next = 1'b0;
            w_halted_next   = 1'b1;
          end else if (r_ir_valid && (jump_en || branch_en)) begin
            w_pc_next       = redirect_pc(jump_en, jump_target, r_ir_pc, branch_offset);
            w_ir_valid_next = 1'b0;
          end else begin
            w_ir_next       = rom_instruction;
            w_ir_pc_next    = r_pc;
            w_ir_valid_next = 1'b1;
            w_pc_next       = ADDR_W'(r_pc + 1'b1);
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign rom_address = r_pc;
  assign pc          = r_pc;
  assign ir          = r_ir;
  assign ir_pc       = r_ir_pc;
  assign ir_valid    = r_ir_valid;
  assign halted      = r_halted;
  assign instr_count = r_count;

endmodule
